// File: rtl/four_bit_decrementer_timer.sv
// Countdown timer on a ripple-borrow decrementer (chain of half-subtractors).
// Loads a start value, decrements once per qualified tick, pulses done for a
// single cycle on reaching zero, and optionally reloads for periodic use.

// One borrow stage: d = a - b_in, borrow out when a=0 and b_in=1.
module four_bit_decrementer_timer_hsub (
   input  logic a_i,
   input  logic b_i,
   output logic d_o,
   output logic b_o
);
   assign d_o = a_i ^ b_i;
   assign b_o = ~a_i & b_i;
endmodule

module four_bit_decrementer_timer #(
   parameter int WIDTH       = 4,
   parameter int AUTO_RELOAD = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             tick,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] saved_q, saved_d;
   logic             busy_q, done_q;

   logic [WIDTH-1:0] dec_d;
   logic [WIDTH:0]   brw;

   // Borrow chain: injecting a borrow at bit 0 computes count-1; the final
   // borrow out is set only when every bit was 0, which doubles as zero detect.
   assign brw[0] = 1'b1;
   for (genvar i = 0; i < WIDTH; i++) begin : g_dec
      four_bit_decrementer_timer_hsub u_hsub (
         .a_i (count_q[i]),
         .b_i (brw[i]),
         .d_o (dec_d[i]),
         .b_o (brw[i+1])
      );
   end

   assign zero  = brw[WIDTH];
   assign count = count_q;
   assign busy  = busy_q;
   assign done  = done_q;

   // Next-state logic; the decrement is only applied with count nonzero so a
   // wrap to all-ones can never be registered.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      saved_d = saved_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               count_d = load_val;
               saved_d = load_val;
               state_d = (load_val != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (tick && !zero) begin
               count_d = dec_d;
               if (count_q == ONE) state_d = DONE;
            end
         end
         DONE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (start) begin
               count_d = load_val;
               saved_d = load_val;
               state_d = (load_val != '0) ? RUN : DONE;
            end else if (AUTO_RELOAD != 0 && saved_q != '0) begin
               count_d = saved_q;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered busy/done decodes of the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         saved_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         saved_q <= saved_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_four_bit_decrementer_timer.sv
// Scoreboard bench: the driver pushes the expected post-edge outputs for each
// cycle it drives; a negedge monitor pops and compares against the DUT.
module tb_four_bit_decrementer_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic [3:0] load_val = '0;
   logic       tick = 1'b0, abort = 1'b0;

   logic [3:0] count0, count1;
   logic       busy0, busy1, done0, done1, zero0, zero1;

   typedef struct {
      logic       sel;
      logic [3:0] c;
      logic       b;
      logic       d;
   } exp_t;

   exp_t q[$];
   logic sel = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   four_bit_decrementer_timer #(.WIDTH(4), .AUTO_RELOAD(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .load_val(load_val), .tick(tick),
      .abort(abort), .count(count0), .busy(busy0), .done(done0), .zero(zero0)
   );

   four_bit_decrementer_timer #(.WIDTH(4), .AUTO_RELOAD(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .load_val(load_val), .tick(tick),
      .abort(abort), .count(count1), .busy(busy1), .done(done1), .zero(zero1)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares one expectation per falling edge when one is pending.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         if (e.sel == 1'b0) begin
            chk("count0", int'(count0), int'(e.c));
            chk("busy0",  int'(busy0),  int'(e.b));
            chk("done0",  int'(done0),  int'(e.d));
            chk("zero0",  int'(zero0),  int'(e.c == 4'd0));
         end else begin
            chk("count1", int'(count1), int'(e.c));
            chk("busy1",  int'(busy1),  int'(e.b));
            chk("done1",  int'(done1),  int'(e.d));
            chk("zero1",  int'(zero1),  int'(e.c == 4'd0));
         end
      end
   end

   task automatic push(input logic [3:0] ec, input logic eb, input logic ed);
      exp_t e;
      e.sel = sel; e.c = ec; e.b = eb; e.d = ed;
      q.push_back(e);
   endtask

   // Drive one cycle of inputs and record the outputs expected after the edge.
   task automatic cyc(input logic st, input logic [3:0] lv, input logic tk,
                      input logic ab, input logic [3:0] ec, input logic eb,
                      input logic ed);
      @(negedge clk); #1;
      start0   = (sel == 1'b0) ? st : 1'b0;
      start1   = (sel == 1'b1) ? st : 1'b0;
      load_val = lv;
      tick     = tk;
      abort    = ab;
      push(ec, eb, ed);
      @(posedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
      $fatal(1, "timeout");
   end

   initial begin : main
      // Reset state observed while rst is held.
      push(4'd0, 1'b0, 1'b0);
      @(negedge clk); #1;
      rst = 1'b0;

      // Basic countdown from 3.
      cyc(1, 4'd3, 1, 0, 4'd3, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd2, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd1, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 1);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 0);
      cyc(0, 4'd0, 0, 0, 4'd0, 0, 0);

      // Gapped ticks, start ignored in RUN, abort beats tick.
      cyc(1, 4'd6, 0, 0, 4'd6, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd5, 1, 0);
      cyc(1, 4'd9, 0, 0, 4'd5, 1, 0);
      cyc(1, 4'd9, 1, 0, 4'd4, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd3, 1, 0);
      cyc(0, 4'd0, 0, 0, 4'd3, 1, 0);
      cyc(0, 4'd0, 1, 1, 4'd3, 0, 0);
      cyc(0, 4'd0, 1, 0, 4'd3, 0, 0);

      // Zero load: single done, no RUN, no wrap.
      cyc(1, 4'd0, 1, 0, 4'd0, 0, 1);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 0);

      // All-ones load: 15 ticks to done.
      cyc(1, 4'd15, 1, 0, 4'd15, 1, 0);
      for (int k = 14; k >= 1; k--) cyc(0, 4'd0, 1, 0, 4'(k), 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 1);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 0);

      // Back-to-back runs via start in DONE, then abort overriding start.
      cyc(1, 4'd1, 1, 0, 4'd1, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 1);
      cyc(1, 4'd2, 1, 0, 4'd2, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd1, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 1);
      cyc(1, 4'd7, 1, 1, 4'd0, 0, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 0);

      // Async reset mid-RUN with count=5, asserted between edges.
      cyc(1, 4'd5, 0, 0, 4'd5, 1, 0);
      @(negedge clk); #1;
      start0 = 1'b0; tick = 1'b0;
      push(4'd0, 1'b0, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 0);
      @(negedge clk); #1;
      rst = 1'b0;
      cyc(1, 4'd2, 1, 0, 4'd2, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd1, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 1);
      cyc(0, 4'd0, 0, 0, 4'd0, 0, 0);

      // Auto-reload instance.
      sel = 1'b1;
      cyc(1, 4'd2, 1, 0, 4'd2, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd1, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 1);
      cyc(0, 4'd0, 1, 0, 4'd2, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd1, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 1);
      cyc(0, 4'd0, 1, 1, 4'd0, 0, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 0);
      cyc(1, 4'd2, 1, 0, 4'd2, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd1, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 1);
      cyc(1, 4'd4, 1, 0, 4'd4, 1, 0);
      cyc(0, 4'd0, 1, 0, 4'd3, 1, 0);
      cyc(0, 4'd0, 1, 1, 4'd3, 0, 0);
      cyc(1, 4'd0, 1, 0, 4'd0, 0, 1);
      cyc(0, 4'd0, 1, 0, 4'd0, 0, 0);

      // Let the monitor drain, bounded.
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
